imm_encoder: RTL and testbench

//  Inverse of the immediate extender: packs a 32-bit immediate into the immediate bit-fields
//  of a RISC-V instruction word for I/S/B/J/U formats, merging with caller-supplied non-imm fields.

---
 rtl/imm_encoder.sv | 141 ++++++++++++++
 tb/tb_imm_encoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the I/S/B/J/U immediate fields of a RISC-V instruction word.
// Two-stage valid/ready pipeline. Optional re-decode check enabled by IMM_ENC_SELFCHECK_EN.
module imm_encoder #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           ImmSrc,
  input  logic [31:0]          imm,
  input  logic [31:0]          base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr,
  output logic                 range_err,
`ifdef IMM_ENC_SELFCHECK_EN
  output logic                 selfchk_fail,
`endif
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] SRC_I = 3'd0;
  localparam logic [2:0] SRC_S = 3'd1;
  localparam logic [2:0] SRC_B = 3'd2;
  localparam logic [2:0] SRC_J = 3'd3;
  localparam logic [2:0] SRC_U = 3'd4;

  // Overwrite the format's immediate field in b; other bits pass through.
  function automatic logic [31:0] place(input logic [2:0] src, input logic [31:0] v,
                                        input logic [31:0] b);
    logic [31:0] r;
    r = b;
    case (src)
      SRC_I: r[31:20] = v[11:0];
      SRC_S: begin
        r[31:25] = v[11:5];
        r[11:7]  = v[4:0];
      end
      SRC_B: begin
        r[31]    = v[12];
        r[30:25] = v[10:5];
        r[11:8]  = v[4:1];
        r[7]     = v[11];
      end
      SRC_J: begin
        r[31]    = v[20];
        r[30:21] = v[10:1];
        r[20]    = v[11];
        r[19:12] = v[19:12];
      end
      SRC_U:   r[31:12] = v[31:12];
      default: r = b;
    endcase
    return r;
  endfunction

  // High bits must be a pure sign extension and dropped low bits must be zero.
  function automatic logic not_repr(input logic [2:0] src, input logic [31:0] v);
    logic e;
    case (src)
      SRC_I, SRC_S: e = !((&v[31:11]) || !(|v[31:11]));
      SRC_B:        e = v[0] || !((&v[31:12]) || !(|v[31:12]));
      SRC_J:        e = v[0] || !((&v[31:20]) || !(|v[31:20]));
      SRC_U:        e = |v[11:0];
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

`ifdef IMM_ENC_SELFCHECK_EN
  // Immediate extender: recovers the immediate a decoder would see.
  function automatic logic [31:0] extract(input logic [2:0] src, input logic [31:0] w);
    logic [31:0] r;
    case (src)
      SRC_I:   r = {{20{w[31]}}, w[31:20]};
      SRC_S:   r = {{20{w[31]}}, w[31:25], w[11:7]};
      SRC_B:   r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      SRC_J:   r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      SRC_U:   r = {w[31:12], 12'b0};
      default: r = 32'b0;
    endcase
    return r;
  endfunction
`endif

  logic        s1_valid;
  logic [2:0]  s1_src;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;
  logic        s1_err;
  logic        s1_adv;
  logic [31:0] s1_instr;

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign s1_instr = place(s1_src, s1_imm, s1_base);

  // Stage 1 capture, stage 2 merge, and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_src       <= 3'b0;
      s1_imm       <= 32'b0;
      s1_base      <= 32'b0;
      s1_err       <= 1'b0;
      out_valid    <= 1'b0;
      instr        <= 32'b0;
      range_err    <= 1'b0;
      err_count    <= '0;
`ifdef IMM_ENC_SELFCHECK_EN
      selfchk_fail <= 1'b0;
`endif
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_src   <= ImmSrc;
        s1_imm   <= imm;
        s1_base  <= base;
        s1_err   <= not_repr(ImmSrc, imm);
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          instr     <= s1_instr;
          range_err <= s1_err;
        end
`ifdef IMM_ENC_SELFCHECK_EN
        selfchk_fail <= s1_valid && !s1_err && (extract(s1_src, s1_instr) != s1_imm);
`endif
      end

      if (out_valid && out_ready && range_err && (err_count != {ERR_CNT_W{1'b1}}))
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: directed format cases, backpressure, reset flush and
// randomized traffic against a queue-based reference model.
module tb_imm_encoder;

  localparam int unsigned ERR_CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           ImmSrc;
  logic [31:0]          imm;
  logic [31:0]          base;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          instr;
  logic                 range_err;
  logic [ERR_CNT_W-1:0] err_count;
`ifdef IMM_ENC_SELFCHECK_EN
  logic                 selfchk_fail;
`endif

  imm_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ImmSrc(ImmSrc),
    .imm(imm), .base(base), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .range_err(range_err),
`ifdef IMM_ENC_SELFCHECK_EN
    .selfchk_fail(selfchk_fail),
`endif
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: {err, instr} from masks, shifts and signed range tests.
  function automatic logic [32:0] model(input logic [2:0] src, input logic [31:0] v,
                                        input logic [31:0] b);
    int signed s;
    logic [31:0] w;
    logic e;
    s = $signed(v);
    case (src)
      3'd0: begin
        w = (b & 32'h000F_FFFF) | ((v & 32'hFFF) << 20);
        e = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        w = (b & 32'h01FF_F07F) | (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = (b & 32'h01FF_F07F) | (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25)
          | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7);
        e = ((v & 32'h1) != 0) || (s < -4096) || (s > 4095);
      end
      3'd3: begin
        w = (b & 32'h0000_0FFF) | (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21)
          | (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12);
        e = ((v & 32'h1) != 0) || (s < -1048576) || (s > 1048575);
      end
      3'd4: begin
        w = (b & 32'h0000_0FFF) | (v & 32'hFFFF_F000);
        e = (v & 32'hFFF) != 0;
      end
      default: begin
        w = b;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  logic [32:0] exp_q[$];
  logic        have_req = 1'b0;
  logic [2:0]  req_src;
  logic [31:0] req_imm;
  logic [31:0] req_base;
  int          exp_cnt = 0;
  int          n_acc = 0;
  int          n_out = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] held_instr;
  logic        held_err;
  logic [31:0] last_instr;
  logic        last_err;
  logic        last_acc;
  logic        last_hs;

  // One clock: drive, sample mid-cycle, score handshakes that occur at the next rising edge.
  task automatic step(input logic ordy);
    logic [32:0] e;
    in_valid  = have_req;
    ImmSrc    = req_src;
    imm       = req_imm;
    base      = req_base;
    out_ready = ordy;
    #1;
    last_acc = in_valid && in_ready;
    last_hs  = out_valid && out_ready;
    if (hold_prev) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_instr", instr, held_instr);
      check("hold_err", 32'(range_err), 32'(held_err));
    end
    check("err_count", 32'(err_count), 32'(exp_cnt));
`ifdef IMM_ENC_SELFCHECK_EN
    check("selfchk", 32'(selfchk_fail), 32'd0);
`endif
    if (last_hs) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("instr", instr, e[31:0]);
        check("range_err", 32'(range_err), 32'(e[32]));
        if (e[32] && exp_cnt < (1 << ERR_CNT_W) - 1) exp_cnt++;
      end
      last_instr = instr;
      last_err   = range_err;
    end
    hold_prev  = out_valid && !out_ready;
    held_instr = instr;
    held_err   = range_err;
    if (last_acc) begin
      exp_q.push_back(model(req_src, req_imm, req_base));
      have_req = 1'b0;
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b);
    have_req = 1'b1;
    req_src  = s;
    req_imm  = v;
    req_base = b;
  endtask

  // Single request with free-flowing output; checks latency and literal result.
  task automatic directed(input string tag, input logic [2:0] s, input logic [31:0] v,
                          input logic [31:0] b, input logic [31:0] exp_w, input logic exp_e);
    int lat;
    bit got;
    set_req(s, v, b);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b1);
      got = last_acc;
    end
    if (!got) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b1);
      lat++;
      got = last_hs;
    end
    if (!got) begin
      check({tag, "_out_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'd2);
      check({tag, "_instr"}, last_instr, exp_w);
      check({tag, "_err"}, 32'(last_err), 32'(exp_e));
    end
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom);
      1:       return 32'(int'($urandom_range(0, 8191)) - 4096);
      2:       return 32'(int'($urandom_range(0, 4194303)) - 2097152) & 32'hFFFF_FFFE;
      default: return 32'($urandom) & 32'hFFFF_F000;
    endcase
  endfunction

  initial begin
    logic [31:0] bp_imm[4];
    int k;
    rst = 1'b1;
    in_valid = 1'b0; ImmSrc = 3'd0; imm = 32'd0; base = 32'd0; out_ready = 1'b0;
    req_src = 3'd0; req_imm = 32'd0; req_base = 32'd0;
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_range_err", 32'(range_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    directed("i_neg1", 3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    directed("s_8",    3'd1, 32'h0000_0008, 32'h0051_2023, 32'h0051_2423, 1'b0);
    directed("b_16",   3'd2, 32'h0000_0010, 32'h0000_0063, 32'h0000_0863, 1'b0);
    directed("j_800",  3'd3, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0);
    directed("u_12345",3'd4, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
    directed("i_ovf",  3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
    directed("b_odd",  3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1);
    directed("illegal",3'd5, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    step(1'b1);
    check("err_count_3", 32'(err_count), 32'd3);

    // Backpressure: 4 back-to-back requests, output stalled for 5 cycles.
    for (int i = 0; i < 4; i++) bp_imm[i] = 32'(int'($urandom_range(0, 4095)) - 2048);
    n_acc = 0;
    n_out = 0;
    k = 0;
    set_req(3'd0, bp_imm[0], 32'h0000_0013);
    for (int c = 0; c < 5; c++) begin
      step(1'b0);
      if (last_acc && k < 3) begin
        k++;
        set_req(3'd0, bp_imm[k], 32'h0000_0013 + 32'(k));
      end
    end
    check("bp_accepted", 32'(n_acc), 32'd2);
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 30 && (n_out < 4 || have_req); c++) begin
      step(1'b1);
      if (last_acc && k < 3) begin
        k++;
        set_req(3'd0, bp_imm[k], 32'h0000_0013 + 32'(k));
      end
    end
    check("bp_out_count", 32'(n_out), 32'd4);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while both stages hold erroneous requests.
    set_req(3'd2, 32'h0000_0005, 32'h0000_0063);
    step(1'b0);
    set_req(3'd2, 32'h0000_0007, 32'h0000_0063);
    step(1'b0);
    #1;
    check("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    exp_q.delete();
    exp_cnt = 0;
    hold_prev = 1'b0;
    have_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    set_req(3'd4, 32'hABCD_E000, 32'h0000_0037);
    step(1'b1);
    check("post_rst_accept", 32'(last_acc), 32'd1);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      if (!have_req && $urandom_range(0, 3) != 0)
        set_req(3'($urandom_range(0, 7)), rand_imm(), 32'($urandom));
      step($urandom_range(0, 9) < 7);
    end
    for (int c = 0; c < 20 && (have_req || exp_q.size() != 0); c++) step(1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
